// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter : round-robin owner arbiter for the shared system bus, with
//               access tracking and a ready-timeout watchdog.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NUM_MASTERS-1:0] m_req_,
    input  logic [NUM_MASTERS-1:0] m_as_,
    input  logic                   m_rdy_,
    output logic [NUM_MASTERS-1:0] m_grnt_,
    output logic [SEL_W-1:0]       bus_owner,
    output logic                   bus_valid,
    output logic                   bus_busy,
    output logic                   bus_err
);

    localparam int                   WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int                   WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0]      WD_LAST   = WD_LAST_I[WD_W-1:0];
    localparam logic                 WD_EN     = (TIMEOUT > 0);
    localparam logic [NUM_MASTERS-1:0] ONE     = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grnt_q;
    logic [SEL_W-1:0]       owner_q;
    logic [SEL_W-1:0]       last_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   err_q;
    logic [WD_W-1:0]        wd_q;

    logic [NUM_MASTERS-1:0] req_act;
    logic [NUM_MASTERS-1:0] as_act;
    logic                   rdy_act;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] cand;
    logic                   own_req;
    logic                   own_as;
    logic                   win_found;
    logic [SEL_W-1:0]       win_idx;
    int                     pos;

    assign req_act  = ~m_req_;
    assign as_act   = ~m_as_;
    assign rdy_act  = ~m_rdy_;
    assign owner_oh = ONE << owner_q;
    assign own_req  = |(req_act & owner_oh);
    assign own_as   = |(as_act & owner_oh);

    // During a handover the releasing owner must not win its own bus back.
    assign cand = req_act & ((state_q == ST_OWNED) ? ~owner_oh : {NUM_MASTERS{1'b1}});

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            pos = int'(last_q) + i;
            if (pos >= NUM_MASTERS) begin
                pos = pos - NUM_MASTERS;
            end
            if (!win_found && (|((cand >> pos) & ONE))) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(pos);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            grnt_q  <= '1;
            owner_q <= '0;
            last_q  <= SEL_W'(NUM_MASTERS - 1);
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        grnt_q  <= ~(ONE << win_idx);
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        valid_q <= 1'b1;
                        state_q <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    // A starting access takes priority over a simultaneous release.
                    if (own_as) begin
                        busy_q  <= 1'b1;
                        wd_q    <= '0;
                        state_q <= ST_BUSY;
                    end else if (!own_req) begin
                        if (win_found) begin
                            grnt_q  <= ~(ONE << win_idx);
                            owner_q <= win_idx;
                            last_q  <= win_idx;
                        end else begin
                            grnt_q  <= '1;
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (rdy_act) begin
                        wd_q <= '0;
                        if (!own_as) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_OWNED;
                        end
                    end else if (WD_EN && (wd_q == WD_LAST)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        grnt_q  <= '1;
                        valid_q <= 1'b0;
                        wd_q    <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    grnt_q  <= '1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_grnt_   = grnt_q;
    assign bus_owner = owner_q;
    assign bus_valid = valid_q;
    assign bus_busy  = busy_q;
    assign bus_err   = err_q;

endmodule

`default_nettype wire
